// File: rtl/phy_rx_serial_parallel_pkg.sv
// Shared types and constants for the PHY lane receiver.
// Contents: alignment/idle symbols, byte and counter widths, receiver state type.
package phy_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned COM_CNT_W = 4;
  localparam int unsigned BCNT_W    = 16;

  localparam logic [BYTE_W-1:0] COM_SYM  = 8'hBC;
  localparam logic [BYTE_W-1:0] IDLE_SYM = 8'h7C;

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    ALIGNING = 2'd1,
    ACTIVE   = 2'd2
  } state_t;

endpackage : phy_pkg

// File: rtl/phy_rx_serial_parallel_if.sv
// Lane receiver bus: serial input and aligned byte output.
// Signals: data_in (serial, MSB first), data_out/valid_out (aligned byte),
//          active (lane locked), byte_cnt (only with PHY_RX_BYTE_CNT_EN).
// Modports: master drives data_in and observes results; slave is the receiver.
interface phy_rx_serial_parallel_if;
  import phy_pkg::*;

  logic              data_in;
  logic [BYTE_W-1:0] data_out;
  logic              valid_out;
  logic              active;
`ifdef PHY_RX_BYTE_CNT_EN
  logic [BCNT_W-1:0] byte_cnt;
`endif

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
`ifdef PHY_RX_BYTE_CNT_EN
    ,
    input  byte_cnt
`endif
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
`ifdef PHY_RX_BYTE_CNT_EN
    ,
    output byte_cnt
`endif
  );

endinterface : phy_rx_serial_parallel_if

// File: rtl/phy_rx_serial_parallel_shift_align.sv
// Serial shift register and byte-boundary counter for one lane.
// Ports: clk_32f, reset_L (async active-low), data_in (serial bit),
//        search (FSM in SEARCH: hold bit counter at 0),
//        nxt (shift register value including the current bit),
//        boundary (current bit completes an aligned byte), com_hit (nxt is COM).
module phy_rx_shift_align
  import phy_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset_L,
  input  logic              data_in,
  input  logic              search,
  output logic [BYTE_W-1:0] nxt,
  output logic              boundary,
  output logic              com_hit
);

  logic [BYTE_W-1:0]    sr;
  logic [BIT_CNT_W-1:0] bit_cnt;

  // Window seen at this edge; comparisons look at it before it is stored.
  assign nxt      = {sr[BYTE_W-2:0], data_in};
  assign com_hit  = (nxt == COM_SYM);
  assign boundary = !search && (bit_cnt == BIT_CNT_W'(BYTE_W - 1));

  // Shift every edge; bit counter only runs once a COM has set the alignment.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      sr <= nxt;
      if (search) bit_cnt <= '0;
      else        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

endmodule : phy_rx_shift_align

// File: rtl/phy_rx_serial_parallel.sv
// Receive-side serial-to-parallel converter for one PHY lane (clk_32f domain).
// Locks on COM_COUNT aligned COM symbols, then delivers each aligned byte on
// data_out with valid_out (COM/IDLE flagged non-valid), held for 8 bit clocks.
// Ports: clk_32f, reset_L (async active-low), bus (slave modport: data_in,
//        data_out, valid_out, active, and byte_cnt when PHY_RX_BYTE_CNT_EN).
// Optional feature macro: PHY_RX_BYTE_CNT_EN (saturating payload byte counter).
module phy_rx_serial_parallel
  import phy_pkg::*;
#(
  parameter int unsigned COM_COUNT = 4
) (
  input logic                      clk_32f,
  input logic                      reset_L,
  phy_rx_serial_parallel_if.slave  bus
);

  state_t               state_q, state_d;
  logic [COM_CNT_W-1:0] com_cnt_q, com_cnt_d;
  logic [BYTE_W-1:0]    nxt;
  logic                 boundary, com_hit;

  logic [BYTE_W-1:0]    data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 active_q, active_d;

  phy_rx_shift_align u_shift (
    .clk_32f  (clk_32f),
    .reset_L  (reset_L),
    .data_in  (bus.data_in),
    .search   (state_q == SEARCH),
    .nxt      (nxt),
    .boundary (boundary),
    .com_hit  (com_hit)
  );

  // State register and COM counter.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= SEARCH;
      com_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      com_cnt_q <= com_cnt_d;
    end
  end

  // Next-state: COM search at any offset, then COM_COUNT-1 further aligned COMs.
  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    unique case (state_q)
      SEARCH: begin
        if (com_hit) begin
          com_cnt_d = COM_CNT_W'(1);
          state_d   = (COM_COUNT == 1) ? ACTIVE : ALIGNING;
        end
      end
      ALIGNING: begin
        if (boundary) begin
          if (com_hit) begin
            if (com_cnt_q + COM_CNT_W'(1) == COM_CNT_W'(COM_COUNT)) begin
              state_d   = ACTIVE;
              com_cnt_d = '0;
            end else begin
              com_cnt_d = com_cnt_q + COM_CNT_W'(1);
            end
          end else begin
            // Broken alignment; this edge is not re-examined as a fresh COM.
            state_d   = SEARCH;
            com_cnt_d = '0;
          end
        end
      end
      ACTIVE:  state_d = ACTIVE;
      default: state_d = SEARCH;
    endcase
  end

  // Output next values: load only at boundaries in ACTIVE, otherwise hold.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    active_d = (state_d == ACTIVE);
    if (state_q == ACTIVE && boundary) begin
      data_d  = nxt;
      valid_d = (nxt != COM_SYM) && (nxt != IDLE_SYM);
    end
  end

  // Output registers.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.active    = active_q;

`ifdef PHY_RX_BYTE_CNT_EN
  logic [BCNT_W-1:0] byte_cnt_q;

  // Saturating count of payload bytes, stepped with each valid load.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      byte_cnt_q <= '0;
    end else if (state_q == ACTIVE && boundary && valid_d && byte_cnt_q != '1) begin
      byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
    end
  end

  assign bus.byte_cnt = byte_cnt_q;
`endif

endmodule : phy_rx_serial_parallel

// File: tb/tb_phy_rx_serial_parallel.sv
// Directed self-checking bench for phy_rx_serial_parallel.
// Two instances share the serial stream: dut (COM_COUNT=4) and dut1 (COM_COUNT=1).
module tb_phy_rx_serial_parallel;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;
  logic din     = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_32f = ~clk_32f;

  phy_rx_serial_parallel_if bus  ();
  phy_rx_serial_parallel_if bus1 ();

  assign bus.data_in  = din;
  assign bus1.data_in = din;

  phy_rx_serial_parallel #(.COM_COUNT(4)) dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  phy_rx_serial_parallel #(.COM_COUNT(1)) dut1 (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .bus     (bus1.slave)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one bit, let the next rising edge sample it, settle 1 time unit.
  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    din = 1'b0;
    reset_L = 1'b0;
    #7;
    reset_L = 1'b1;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic v, input logic a);
    check({tag, ".data"},   16'(bus.data_out),  16'(d));
    check({tag, ".valid"},  16'(bus.valid_out), 16'(v));
    check({tag, ".active"}, 16'(bus.active),    16'(a));
  endtask

  // Lock dut with four BCs starting from a cleared shift register.
  task automatic lock4();
    for (int k = 0; k < 4; k++) send_byte(8'hBC);
  endtask

  initial begin
    // 1: reset then zeros
    reset_L = 1'b0;
    #3;
    check_out("t1_in_reset", 8'h00, 1'b0, 1'b0);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_byte(8'h00);
      check_out("t1_zeros", 8'h00, 1'b0, 1'b0);
    end

    // 2: junk bits, BC x4, A5 7C 3C
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    check_out("t2_bc3", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    check_out("t2_bc4", 8'h00, 1'b0, 1'b1);
    send_byte(8'hA5);
    check_out("t2_a5", 8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    check_out("t2_a5_hold", 8'hA5, 1'b1, 1'b1);
    send_bit(1'b0);
    check_out("t2_00", 8'h00, 1'b1, 1'b1);
    send_byte(8'h7C);
    check_out("t2_7c", 8'h7C, 1'b0, 1'b1);
    send_byte(8'h3C);
    check_out("t2_3c", 8'h3C, 1'b1, 1'b1);
    send_byte(8'hBC);
    check_out("t2_com_active", 8'hBC, 1'b0, 1'b1);

    // 4: async reset mid-byte while ACTIVE, then relock needs 4 COMs
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    #2;
    reset_L = 1'b0;
    #1;
    check_out("t4_async", 8'h00, 1'b0, 1'b0);
    #1;
    reset_L = 1'b1;
    din = 1'b0;
    @(posedge clk_32f);
    #1;
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    check_out("t4_relock3", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    check_out("t4_relock4", 8'h00, 1'b0, 1'b1);

    // 3: BC BC 5A aborts, then four BCs needed
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h5A);
    check_out("t3_5a", 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    check_out("t3_bc3", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    check_out("t3_bc4", 8'h00, 1'b0, 1'b1);
    send_byte(8'h66);
    check_out("t3_66", 8'h66, 1'b1, 1'b1);

    // 5: COM_COUNT=1 instance
    do_reset();
    send_byte(8'hBC);
    check("t5_active", 16'(bus1.active), 16'h1);
    check("t5_valid0", 16'(bus1.valid_out), 16'h0);
    send_byte(8'h11);
    check("t5_data", 16'(bus1.data_out), 16'h11);
    check("t5_valid", 16'(bus1.valid_out), 16'h1);
    send_byte(8'h7C);
    check("t5_idle", 16'(bus1.valid_out), 16'h0);

`ifdef PHY_RX_BYTE_CNT_EN
    // 6: byte counter with payload/IDLE mix and saturation
    do_reset();
    check("t6_reset", bus.byte_cnt, 16'h0000);
    lock4();
    send_byte(8'hA5); send_byte(8'h7C); send_byte(8'h3C); send_byte(8'h11);
    send_byte(8'h7C); send_byte(8'h22); send_byte(8'h33);
    check("t6_cnt5", bus.byte_cnt, 16'd5);
    force dut.byte_cnt_q = 16'hFFFF;
    #1;
    release dut.byte_cnt_q;
    send_byte(8'h44);
    check("t6_sat", bus.byte_cnt, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_phy_rx_serial_parallel
